mem_rd_streamer: RTL

- Downstream consumer of the memory read port.
- Given a start address and a length, issues sequential rd_addr/rd_en requests to the memory.
- Captures rd_data_out, which arrives one cycle after rd_en, into a small credit-managed FIFO.
- Presents the data as a valid/ready stream with a last flag, so back-pressure from downstream never drops a memory read.

---
 rtl/mem_rd_streamer_pkg.sv | 19 +
 rtl/mem_rd_fifo.sv | 72 +++++++
 rtl/mem_rd_streamer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_rd_streamer_pkg.sv
// Shared types and constants for the memory read streamer.
// Optional parity output is enabled with MEM_RD_STREAMER_PARITY_EN.
package mem_rd_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    // Cycles from issuing a read to pushing its data into the FIFO
    localparam int READ_LAT = 2;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mem_rd_fifo.sv
// Synchronous FIFO whose head entry is held in an output register, so data
// and valid leave straight from flops; count includes the head entry.
module mem_rd_fifo
    import mem_rd_streamer_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    parameter int CW    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_next;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] head_next;
    logic             do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // The next head is the incoming word when nothing else remains after the pop
    always_comb begin
        do_pop      = pop && valid;
        count_next  = count + CW'(push) - CW'(do_pop);
        rd_ptr_next = rd_ptr + PW'(do_pop);
        head_next   = (count == CW'(do_pop)) ? din : store[rd_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            store[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
            valid  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            valid  <= (count_next != '0);
            if (count_next != '0) begin
                dout <= head_next;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst) !(push && full))
        else $fatal(1, "mem_rd_fifo: push into full FIFO");

endmodule

// File: rtl/mem_rd_streamer.sv
// Streams len sequential memory words out as a valid/ready stream with last.
// Define MEM_RD_STREAMER_PARITY_EN to add the m_parity output.
module mem_rd_streamer
    import mem_rd_streamer_pkg::*;
#(
    parameter int DATA       = 32,
    parameter int ADDR       = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [ADDR-1:0] start_addr,
    input  logic [ADDR:0]   len,
    output logic            busy,
    output logic            done,
    output logic            mem_rd_en,
    output logic [ADDR-1:0] mem_rd_addr,
    input  logic [DATA-1:0] mem_rd_data,
    output logic [DATA-1:0] m_data,
`ifdef MEM_RD_STREAMER_PARITY_EN
    output logic            m_parity,
`endif
    output logic            m_valid,
    input  logic            m_ready,
    output logic            m_last
);

    localparam int CW = cnt_w(FIFO_DEPTH);
`ifdef MEM_RD_STREAMER_PARITY_EN
    localparam int FW = DATA + 2;
`else
    localparam int FW = DATA + 1;
`endif

    state_t          state;
    logic [ADDR-1:0] addr_q;
    logic [ADDR:0]   remaining;
    logic            rd_last;
    logic            cap_valid;
    logic            cap_last;
    logic [1:0]      inflight;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [FW-1:0]   fifo_din;
    logic [FW-1:0]   fifo_dout;
    logic            credit;
    logic            issue;
    logic            beat;

    // Reads still in the memory pipeline already own a FIFO slot
    assign credit = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
    assign issue  = (state == ISSUE) && credit;
    assign beat   = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            addr_q      <= '0;
            remaining   <= '0;
            rd_last     <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (len != '0) begin
                            addr_q    <= start_addr;
                            remaining <= len;
                            state     <= ISSUE;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (credit) begin
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= addr_q;
                        addr_q      <= addr_q + ADDR'(1);
                        remaining   <= remaining - (ADDR+1)'(1);
                        rd_last     <= (remaining == (ADDR+1)'(1));
                        if (remaining == (ADDR+1)'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (inflight == 2'd0 && beat && m_last) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory data lands one cycle after rd_en; push it the cycle after that
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_valid <= 1'b0;
            cap_last  <= 1'b0;
            inflight  <= 2'd0;
        end else begin
            cap_valid <= mem_rd_en;
            cap_last  <= rd_last;
            inflight  <= inflight + {1'b0, issue} - {1'b0, cap_valid};
        end
    end

`ifdef MEM_RD_STREAMER_PARITY_EN
    assign fifo_din = {^mem_rd_data, cap_last, mem_rd_data};
    assign m_parity = fifo_dout[DATA+1];
`else
    assign fifo_din = {cap_last, mem_rd_data};
`endif
    assign m_data = fifo_dout[DATA-1:0];
    assign m_last = fifo_dout[DATA];

    mem_rd_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cap_valid),
        .din   (fifo_din),
        .pop   (m_ready),
        .dout  (fifo_dout),
        .valid (m_valid),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assert property (@(posedge clk) disable iff (!rst) issue |-> !fifo_full)
        else $error("mem_rd_streamer: read issued with FIFO full");
    assert property (@(posedge clk) disable iff (!rst) inflight <= 2'(READ_LAT))
        else $error("mem_rd_streamer: too many reads in flight");
    assert property (@(posedge clk) disable iff (!rst) (state == IDLE) |-> fifo_empty)
        else $error("mem_rd_streamer: FIFO not empty while idle");

endmodule
